// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: CTI encodings used by the caches and the
// memory arbiter, plus the arbiter state type.
package wb_pkg;

  localparam logic [2:0] CC  = 3'b000;  // classic cycle
  localparam logic [2:0] CAB = 3'b001;  // constant-address burst
  localparam logic [2:0] IBC = 3'b010;  // incrementing burst
  localparam logic [2:0] EOB = 3'b111;  // end of burst

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

endpackage : wb_pkg

// File: rtl/wb_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set request at or
// after ptr_i (with wrap-around) as a one-hot grant.
module rr_pick #(
  parameter int N_REQ = 2,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic             valid_o
);

  logic [2*N_REQ-1:0] req_dbl;
  logic [2*N_REQ-1:0] gnt_dbl;
  logic [N_REQ-1:0]   rot_req;
  logic [N_REQ-1:0]   rot_gnt;
  logic               found;

  // Rotate requests so ptr_i lands on bit 0, fixed-priority pick, rotate back.
  always_comb begin
    // NOTE: every signal gets a default before any conditional assignment,
    // otherwise paths that skip the assignment infer a latch.
    req_dbl = {req_i, req_i} >> ptr_i;
    rot_req = req_dbl[N_REQ-1:0];
    rot_gnt = '0;
    found   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (rot_req[k] && !found) begin
        rot_gnt[k] = 1'b1;
        found      = 1'b1;
      end
    end
    gnt_dbl = {rot_gnt, rot_gnt} << ptr_i;
    gnt_o   = gnt_dbl[2*N_REQ-1:N_REQ];
    valid_o = found;
  end

endmodule : rr_pick

// File: rtl/wb_mem_arbiter.sv
// Round-robin Wishbone arbiter sharing the SDRAM controller bus between cache
// masters; ownership lasts for a whole CYC. Optional watchdog: ARB_TIMEOUT_EN.
module wb_mem_arbiter
  import wb_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    R_CYC,
  input  logic [N_REQ-1:0]    R_STB,
  input  logic [N_REQ-1:0]    R_WE,
  input  logic [32*N_REQ-1:0] R_ADR,
  input  logic [32*N_REQ-1:0] R_DAT_O,
  input  logic [3*N_REQ-1:0]  R_CTI,
  output logic [31:0]         R_DAT_I,
  output logic [N_REQ-1:0]    R_ACK,
  output logic [N_REQ-1:0]    R_ERR,
  output logic [N_REQ-1:0]    R_RTY,
  output logic                M_CYC,
  output logic                M_STB,
  output logic                M_WE,
  output logic [31:0]         M_ADR,
  output logic [31:0]         M_DAT_O,
  output logic [2:0]          M_CTI,
  input  logic [31:0]         M_DAT_I,
  input  logic                M_ACK,
  input  logic                M_ERR,
  input  logic                M_RTY,
  output logic [N_REQ-1:0]    GRANT
);

  localparam int PTR_W = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("wb_mem_arbiter: N_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] owner_idx, next_ptr;
  logic [N_REQ-1:0] pick_gnt;
  logic             pick_valid;
  logic             owner_cyc, owner_stb, owner_we;
  logic [31:0]      owner_adr, owner_dat;
  logic [2:0]       owner_cti;
  logic             timeout_fire;

  rr_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_pick (
    .req_i   (R_CYC),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (pick_gnt),
    .valid_o (pick_valid)
  );

  // AND-OR mux on the one-hot grant: an idle arbiter drives all zeros (CTI=CC).
  always_comb begin
    owner_cyc = 1'b0;
    owner_stb = 1'b0;
    owner_we  = 1'b0;
    owner_adr = '0;
    owner_dat = '0;
    owner_cti = CC;
    owner_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        owner_cyc = R_CYC[i];
        owner_stb = R_STB[i];
        owner_we  = R_WE[i];
        owner_adr = R_ADR[32*i +: 32];
        owner_dat = R_DAT_O[32*i +: 32];
        owner_cti = R_CTI[3*i +: 3];
        owner_idx = PTR_W'(i);
      end
    end
  end

  assign next_ptr = (owner_idx == PTR_W'(N_REQ - 1)) ? '0 : owner_idx + 1'b1;

`ifdef ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            stalled;
  logic            any_term;

  assign any_term = M_ACK | M_ERR | M_RTY;

  always_comb begin
    stalled      = (state_q == BUSY) && owner_cyc && owner_stb && !any_term;
    timeout_fire = stalled && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
    wd_d         = wd_q;
    if (state_q != BUSY || any_term || timeout_fire) begin
      wd_d = '0;
    end else if (stalled) begin
      wd_d = wd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) wd_q <= '0;
    else     wd_q <= wd_d;
  end
`else
  assign timeout_fire = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_gnt;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Only a dropped CYC (or the watchdog) ends ownership; ERR/RTY do not.
        if (!owner_cyc || timeout_fire) begin
          grant_d  = '0;
          rr_ptr_d = next_ptr;
          state_d  = IDLE;
        end
      end
    endcase
  end

  // NOTE: reset is synchronous, so it sits inside the clocked branch and
  // rst is not in the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign M_CYC   = owner_cyc & ~timeout_fire;
  assign M_STB   = owner_stb & ~timeout_fire;
  assign M_WE    = owner_we;
  assign M_ADR   = owner_adr;
  assign M_DAT_O = owner_dat;
  assign M_CTI   = owner_cti;

  assign R_DAT_I = M_DAT_I;
  assign R_ACK   = grant_q & {N_REQ{M_ACK & ~timeout_fire}};
  assign R_ERR   = grant_q & {N_REQ{M_ERR | timeout_fire}};
  assign R_RTY   = grant_q & {N_REQ{M_RTY & ~timeout_fire}};
  assign GRANT   = grant_q;

endmodule : wb_mem_arbiter

// File: doc/wb_mem_arbiter.md
Name: wb_mem_arbiter

Overview:
- Wishbone round-robin arbiter that shares the single SDRAM memory-controller master bus between N cache requesters (instruction cache and data cache by default).
- Each requester connects its cache master port to one requester slot.
- The arbiter grants whole bus cycles: ownership is held while the owner's CYC stays high, so multi-beat miss fills and writebacks are never interleaved.
- Sits between the caches and the memory controller.

Parameters:
- N_REQ, 2, number of requesters (2..8); index 0 has highest priority after reset.
- TIMEOUT_CYCLES, 1024, watchdog limit in clocks; used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- R_CYC  in  N_REQ  per-requester cycle
- R_STB  in  N_REQ  per-requester strobe
- R_WE  in  N_REQ  per-requester write enable
- R_ADR  in  32*N_REQ  flattened addresses; slot i = bits [32i+31:32i]
- R_DAT_O  in  32*N_REQ  flattened write data from requesters
- R_CTI  in  3*N_REQ  flattened cycle type identifiers
- R_DAT_I  out  32  read data, broadcast to all requesters
- R_ACK  out  N_REQ  per-requester acknowledge
- R_ERR  out  N_REQ  per-requester error
- R_RTY  out  N_REQ  per-requester retry
- M_CYC  out  1  memory bus cycle
- M_STB  out  1  memory bus strobe
- M_WE  out  1  memory bus write enable
- M_ADR  out  32  memory bus address
- M_DAT_O  out  32  memory bus write data
- M_CTI  out  3  memory bus cycle type
- M_DAT_I  in  1x32  memory bus read data
- M_ACK  in  1  memory bus acknowledge
- M_ERR  in  1  memory bus error
- M_RTY  in  1  memory bus retry
- GRANT  out  N_REQ  registered one-hot owner; all zero when idle

Behaviour:
- Registers: state (IDLE, BUSY), GRANT (one-hot), rr_ptr (log2 N_REQ bits).
- Reset values: state=IDLE, GRANT=0, rr_ptr=0.
- When GRANT=0:
  - M_CYC, M_STB and M_WE are 0, M_ADR=0, M_DAT_O=0, M_CTI=3'b000 (CC).
  - All R_ACK/R_ERR/R_RTY are 0.
- IDLE state:
  - If any R_CYC is high, select the first requester with R_CYC high, searching from rr_ptr upward with wrap-around.
  - Set GRANT to that requester one-hot and go to BUSY.
  - Arbitration latency is 1 clock: the requester raises CYC at clock t and sees M_CYC high from t+1.
- BUSY state, datapath:
  - M_CYC/M_STB/M_WE/M_ADR/M_DAT_O/M_CTI are a combinational mux of the granted slot.
  - M_ACK/M_ERR/M_RTY route combinationally to the granted slot only; other slots see 0.
  - R_DAT_I = M_DAT_I at all times.
- BUSY state, release:
  - Release only when R_CYC[owner] goes low. STB-low gaps with CYC held high (between burst beats) keep ownership.
  - M_ERR and M_RTY do not release; the requester must drop CYC.
  - On release: GRANT=0, rr_ptr = owner+1 (mod N_REQ), go to IDLE.
  - This guarantees at least one idle clock with M_CYC low between owners.
- Simultaneous requests: resolved purely by rr_ptr order.
- Wrap-around: owner N_REQ-1 sets rr_ptr to 0.
- A requester that drops and re-raises CYC after release loses priority to any other pending requester.
- Requests from non-owners stay pending with no ACK/ERR/RTY, no matter how long.
- Reset mid-cycle: GRANT clears on the next edge and M_CYC falls with it. No termination is sent to the requester; the caches are reset by the same rst.
- CTI is passed through unmodified; the arbiter does not end bursts on EOB, only on CYC.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined, a watchdog counter runs in BUSY:
  - It counts clocks in which M_STB is high and none of M_ACK/M_ERR/M_RTY is asserted, and clears on any termination and in IDLE.
  - When it reaches TIMEOUT_CYCLES, the arbiter drives R_ERR[owner]=1 for exactly one clock.
  - In that clock it forces M_CYC/M_STB low, then releases ownership as in a normal release: rr_ptr advances, go to IDLE.
  - Subsequent memory terminations for the abandoned cycle are ignored.
- When undefined, there is no counter, a stalled slave hangs its owner indefinitely, and TIMEOUT_CYCLES is unused.

Decomposition:
- Shared package wb_pkg holds:
  - CTI constants CC=3'b000, CAB=3'b001, IBC=3'b010, EOB=3'b111.
  - typedef arb_state_t {IDLE, BUSY}.
- The caches import the same CTI constants.
- Sub-module rr_pick: combinational round-robin priority picker. Inputs are the request vector and rr_ptr; output is a one-hot grant plus a valid flag. It is parameterised by N_REQ and reusable.

Test Plan:
- Only requester 1 raises CYC/STB with ADR=0x0000_1000, WE=0 -> GRANT=2'b10 after 1 clock; M_ADR=0x0000_1000; M_DAT_I=0xDEADBEEF with M_ACK -> R_ACK[1]=1, R_DAT_I=0xDEADBEEF, R_ACK[0]=0.
- Both raise CYC in the same clock after reset -> requester 0 granted; after requester 0 drops CYC, there is 1 idle clock with M_CYC=0, then GRANT=2'b10.
- Requester 0 runs a 256-beat IBC burst, dropping STB for 1 clock between beats while holding CYC, while requester 1 requests throughout -> GRANT stays 2'b01 for all 256 beats; requester 1 is granted only after CYC[0] falls.
- M_RTY during requester 1's cycle -> R_RTY[1]=1 and R_RTY[0]=0; ownership is kept until CYC[1] drops.
- Assert rst while GRANT=2'b01 mid-burst -> next edge gives GRANT=0, M_CYC=0, rr_ptr=0.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: owner holds STB with no slave response -> R_ERR[owner] pulses 1 clock at the 16th stalled clock, M_CYC falls, and the other requester is granted next.
